// File: rtl/pit_bus_master.sv
// pit_bus_master
// Host-side initiator for the 8254 CPU bus. Turns single-cycle register
// requests into sequenced active-low ChipSelect/Read/Write strobes with
// address and data phases, and returns read data to the requester.
//
// Optional feature macro: PIT_BUS_MASTER_WORD_EN
//   When defined, ReqWord=1 performs two byte transfers (LSB then MSB) to the
//   same address, separated by one GAP cycle, with a single RspValid at the end.
//   When undefined, ReqWord and ReqData[15:8] are ignored and reads return
//   RspData[15:8]=0.
//
// Ports:
//   Clock, Reset         - single clock, synchronous active-high reset
//   ReqValid/ReqReady    - request handshake (ReqReady high only in IDLE)
//   ReqWrite, ReqAddr    - direction and {A1,A0} target register
//   ReqWord, ReqData     - word access select and write data (LSB in [7:0])
//   RspValid, RspData    - one-cycle completion pulse and read data
//   ChipSelect/Read/Write- active-low 8254 bus strobes
//   A0, A1               - register address pins
//   DataOut/DataOutEnable- write data and bus drive enable
//   DataIn               - read data from the 8254
// All outputs are registered.

module pit_bus_master #(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [1:0]  ReqAddr,
    input  logic        ReqWord,
    input  logic [15:0] ReqData,
    output logic        RspValid,
    output logic [15:0] RspData,
    output logic        ChipSelect,
    output logic        Read,
    output logic        Write,
    output logic        A0,
    output logic        A1,
    output logic [7:0]  DataOut,
    output logic        DataOutEnable,
    input  logic [7:0]  DataIn
);

    localparam int MAXP = (SETUP_CYCLES > STROBE_CYCLES) ?
                          ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES) :
                          ((STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES);
    // Counter runs from N-1 down to 0, so clog2(N) bits suffice; keep at least one bit.
    localparam int CW = (MAXP > 1) ? $clog2(MAXP) : 1;
`ifdef PIT_BUS_MASTER_WORD_EN
    localparam int DW = 16;
`else
    localparam int DW = 8;
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3
`ifdef PIT_BUS_MASTER_WORD_EN
        ,ST_GAP   = 3'd4
`endif
    } state_t;

    state_t          state_r, state_n_s;
    logic [CW-1:0]   cnt_r, cnt_n_s;
    logic            wr_r, wr_n_s;
    logic [1:0]      addr_r, addr_n_s;
    logic [DW-1:0]   data_r, data_n_s;
    logic            capture_s;
    logic            done_s;
    logic            active_s;
    logic            strobe_s;
    logic [7:0]      byte_s;
`ifdef PIT_BUS_MASTER_WORD_EN
    logic            word_r, word_n_s;
    logic            second_r, second_n_s;
`else
    logic            unused_s;
    assign unused_s = ^{ReqWord, ReqData[15:8]};
`endif

    // Next-state, phase counter and request-latch logic.
    always_comb begin
        state_n_s  = state_r;
        cnt_n_s    = cnt_r;
        wr_n_s     = wr_r;
        addr_n_s   = addr_r;
        data_n_s   = data_r;
        capture_s  = 1'b0;
        done_s     = 1'b0;
`ifdef PIT_BUS_MASTER_WORD_EN
        word_n_s   = word_r;
        second_n_s = second_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (ReqValid) begin
                    state_n_s  = ST_SETUP;
                    cnt_n_s    = CW'(SETUP_CYCLES - 1);
                    wr_n_s     = ReqWrite;
                    addr_n_s   = ReqAddr;
                    data_n_s   = ReqData[DW-1:0];
`ifdef PIT_BUS_MASTER_WORD_EN
                    word_n_s   = ReqWord;
                    second_n_s = 1'b0;
`endif
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_n_s = ST_STROBE;
                    cnt_n_s   = CW'(STROBE_CYCLES - 1);
                end else begin
                    cnt_n_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            ST_STROBE: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_n_s = ST_HOLD;
                    cnt_n_s   = CW'(HOLD_CYCLES - 1);
                    capture_s = ~wr_r;
                end else begin
                    cnt_n_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            ST_HOLD: begin
                if (cnt_r == {CW{1'b0}}) begin
`ifdef PIT_BUS_MASTER_WORD_EN
                    if (word_r && !second_r) begin
                        state_n_s = ST_GAP;
                    end else begin
                        state_n_s = ST_IDLE;
                        done_s    = 1'b1;
                    end
`else
                    state_n_s = ST_IDLE;
                    done_s    = 1'b1;
`endif
                end else begin
                    cnt_n_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
                end
            end
`ifdef PIT_BUS_MASTER_WORD_EN
            ST_GAP: begin
                state_n_s  = ST_SETUP;
                cnt_n_s    = CW'(SETUP_CYCLES - 1);
                second_n_s = 1'b1;
            end
`endif
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // Pin values for the upcoming cycle, derived from the next state so the
    // registered outputs line up with the state they belong to.
    always_comb begin
        active_s = (state_n_s == ST_SETUP) || (state_n_s == ST_STROBE) ||
                   (state_n_s == ST_HOLD);
        strobe_s = (state_n_s == ST_STROBE);
`ifdef PIT_BUS_MASTER_WORD_EN
        if (second_n_s) begin
            byte_s = data_n_s[15:8];
        end else begin
            byte_s = data_n_s[7:0];
        end
`else
        byte_s = data_n_s[7:0];
`endif
    end

    // State, latched request and registered pin outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r       <= ST_IDLE;
            cnt_r         <= {CW{1'b0}};
            wr_r          <= 1'b0;
            addr_r        <= 2'b00;
            data_r        <= {DW{1'b0}};
`ifdef PIT_BUS_MASTER_WORD_EN
            word_r        <= 1'b0;
            second_r      <= 1'b0;
`endif
            ReqReady      <= 1'b1;
            RspValid      <= 1'b0;
            RspData       <= 16'h0000;
            ChipSelect    <= 1'b1;
            Read          <= 1'b1;
            Write         <= 1'b1;
            A0            <= 1'b0;
            A1            <= 1'b0;
            DataOut       <= 8'h00;
            DataOutEnable <= 1'b0;
        end else begin
            state_r       <= state_n_s;
            cnt_r         <= cnt_n_s;
            wr_r          <= wr_n_s;
            addr_r        <= addr_n_s;
            data_r        <= data_n_s;
`ifdef PIT_BUS_MASTER_WORD_EN
            word_r        <= word_n_s;
            second_r      <= second_n_s;
`endif
            ReqReady      <= (state_n_s == ST_IDLE);
            RspValid      <= done_s;
            ChipSelect    <= ~active_s;
            Read          <= ~(strobe_s && !wr_n_s);
            Write         <= ~(strobe_s && wr_n_s);
            A0            <= active_s & addr_n_s[0];
            A1            <= active_s & addr_n_s[1];
            DataOutEnable <= active_s & wr_n_s;
            DataOut       <= (active_s && wr_n_s) ? byte_s : 8'h00;
            // Read data lands at the edge closing the last strobe cycle.
            if (capture_s) begin
`ifdef PIT_BUS_MASTER_WORD_EN
                if (second_r) begin
                    RspData[15:8] <= DataIn;
                end else begin
                    RspData <= {8'h00, DataIn};
                end
`else
                RspData <= {8'h00, DataIn};
`endif
            end else begin
                RspData <= RspData;
            end
        end
    end

endmodule

// File: tb/tb_pit_bus_master.sv
// Self-checking bench for pit_bus_master (default timing parameters).
// Expected pin values per cycle are derived from the transfer timeline:
// SETUP cycles 1..S, STROBE S+1..S+T, HOLD S+T+1..S+T+H, response at
// S+T+H+1; word accesses (with PIT_BUS_MASTER_WORD_EN) repeat the byte
// timeline after one GAP cycle.

module tb_pit_bus_master;

    localparam int S = 1;
    localparam int T = 2;
    localparam int H = 1;
    localparam int N = S + T + H;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        ReqValid = 1'b0;
    logic        ReqReady;
    logic        ReqWrite = 1'b0;
    logic [1:0]  ReqAddr = 2'b00;
    logic        ReqWord = 1'b0;
    logic [15:0] ReqData = 16'h0000;
    logic        RspValid;
    logic [15:0] RspData;
    logic        ChipSelect;
    logic        Read;
    logic        Write;
    logic        A0;
    logic        A1;
    logic [7:0]  DataOut;
    logic        DataOutEnable;
    logic [7:0]  DataIn = 8'h00;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] rsp_model = 16'h0000;

    pit_bus_master #(.SETUP_CYCLES(S), .STROBE_CYCLES(T), .HOLD_CYCLES(H)) dut (
        .Clock(Clock), .Reset(Reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
        .ReqAddr(ReqAddr), .ReqWord(ReqWord), .ReqData(ReqData),
        .RspValid(RspValid), .RspData(RspData),
        .ChipSelect(ChipSelect), .Read(Read), .Write(Write),
        .A0(A0), .A1(A1), .DataOut(DataOut), .DataOutEnable(DataOutEnable),
        .DataIn(DataIn)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [1:0] ad, input logic wd,
                         input logic [15:0] d);
        ReqValid = 1'b1;
        ReqWrite = wr;
        ReqAddr  = ad;
        ReqWord  = wd;
        ReqData  = d;
    endtask

    // Runs one transfer whose request is already offered; the next edge is
    // the acceptance edge. Returns #1 into the response cycle.
    task automatic run(input logic wr, input logic [1:0] ad, input logic wd,
                       input logic [15:0] d, input logic [7:0] din_lo,
                       input logic [7:0] din_hi, input logic [7:0] junk);
        int   nb;
        int   tot;
        int   bidx;
        int   rel;
        logic fin;
        logic gap;
        logic act;
        logic stb;
        logic [7:0] bexp;
`ifdef PIT_BUS_MASTER_WORD_EN
        nb = wd ? 2 : 1;
`else
        nb = 1;
`endif
        tot = (nb == 2) ? 2 * N + 1 : N;
        chk("ready_at_offer", {15'd0, ReqReady}, 16'd1);
        @(posedge Clock); #1;
        ReqValid = 1'b0;
        for (int k = 1; k <= tot + 1; k++) begin
            if (k > 1) begin
                @(posedge Clock); #1;
            end
            bidx = (k > N + 1) ? 1 : 0;
            rel  = k - bidx * (N + 1);
            fin  = (k == tot + 1);
            gap  = (nb == 2) && (k == N + 1);
            act  = !fin && !gap;
            stb  = act && (rel > S) && (rel <= S + T);
            bexp = (bidx == 1) ? d[15:8] : d[7:0];
            if (fin && !wr) begin
                rsp_model = {((nb == 2) ? din_hi : 8'h00), din_lo};
            end
            chk("chip_select", {15'd0, ChipSelect}, {15'd0, !act});
            chk("read_strobe", {15'd0, Read}, {15'd0, !(stb && !wr)});
            chk("write_strobe", {15'd0, Write}, {15'd0, !(stb && wr)});
            chk("data_out_en", {15'd0, DataOutEnable}, {15'd0, act && wr});
            chk("req_ready", {15'd0, ReqReady}, {15'd0, fin});
            chk("rsp_valid", {15'd0, RspValid}, {15'd0, fin});
            if (act) begin
                chk("address", {14'd0, A1, A0}, {14'd0, ad});
            end
            if (act && wr) begin
                chk("data_out", {8'd0, DataOut}, {8'd0, bexp});
            end
            if (fin) begin
                chk("rsp_data", RspData, rsp_model);
            end
            DataIn = stb ? ((bidx == 1) ? din_hi : din_lo) : junk;
        end
    endtask

    logic        r_wr;
    logic [1:0]  r_ad;
    logic        r_wd;
    logic [15:0] r_d;
    logic [7:0]  r_lo;
    logic [7:0]  r_hi;
    logic [7:0]  r_junk;

    initial begin
        // Reset held two cycles, then released.
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
        @(posedge Clock); #1;
        chk("rst_ready", {15'd0, ReqReady}, 16'd1);
        chk("rst_rsp_valid", {15'd0, RspValid}, 16'd0);
        chk("rst_rsp_data", RspData, 16'h0000);
        chk("rst_cs", {15'd0, ChipSelect}, 16'd1);
        chk("rst_rd_wr", {14'd0, Read, Write}, 16'd3);
        chk("rst_addr", {14'd0, A1, A0}, 16'd0);
        chk("rst_dout", {8'd0, DataOut}, 16'd0);
        chk("rst_doe", {15'd0, DataOutEnable}, 16'd0);

        // Directed write to the control register.
        issue(1'b1, 2'd3, 1'b0, 16'h0034);
        run(1'b1, 2'd3, 1'b0, 16'h0034, 8'h00, 8'h00, 8'h00);

        // Directed read of counter 1; bus is 0x00 outside the strobe.
        @(posedge Clock); #1;
        issue(1'b0, 2'd1, 1'b0, 16'h0000);
        run(1'b0, 2'd1, 1'b0, 16'h0000, 8'hA5, 8'h00, 8'h00);

        // Back-to-back: second request offered in the response cycle.
        issue(1'b1, 2'd0, 1'b0, 16'h5A77);
        run(1'b1, 2'd0, 1'b0, 16'h5A77, 8'h00, 8'h00, 8'hFF);

        // Word read of counter 0 (single byte when the feature is off).
        issue(1'b0, 2'd0, 1'b1, 16'h0000);
        run(1'b0, 2'd0, 1'b1, 16'h0000, 8'h12, 8'h34, 8'hEE);

        // Reset during STROBE of a write aborts the transfer.
        @(posedge Clock); #1;
        issue(1'b1, 2'd2, 1'b0, 16'h00C3);
        @(posedge Clock); #1;
        ReqValid = 1'b0;
        @(posedge Clock); #1;
        chk("abort_in_strobe", {15'd0, Write}, 16'd0);
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        rsp_model = 16'h0000;
        chk("abort_write", {15'd0, Write}, 16'd1);
        chk("abort_cs", {15'd0, ChipSelect}, 16'd1);
        chk("abort_doe", {15'd0, DataOutEnable}, 16'd0);
        chk("abort_rsp_data", RspData, 16'h0000);
        for (int i = 0; i < 6; i++) begin
            chk("abort_no_rsp", {15'd0, RspValid}, 16'd0);
            chk("abort_idle_cs", {15'd0, ChipSelect}, 16'd1);
            @(posedge Clock); #1;
        end
        issue(1'b0, 2'd2, 1'b0, 16'h0000);
        run(1'b0, 2'd2, 1'b0, 16'h0000, 8'h3C, 8'h00, 8'h81);

        // Randomized transfers, sometimes chained back-to-back.
        for (int i = 0; i < 40; i++) begin
            r_wr   = 1'($urandom_range(0, 1));
            r_ad   = 2'($urandom_range(0, 3));
            r_wd   = 1'($urandom_range(0, 1));
            r_d    = 16'($urandom);
            r_lo   = 8'($urandom);
            r_hi   = 8'($urandom);
            r_junk = 8'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                @(posedge Clock); #1;
                chk("idle_no_rsp", {15'd0, RspValid}, 16'd0);
                chk("idle_rsp_hold", RspData, rsp_model);
            end
            issue(r_wr, r_ad, r_wd, r_d);
            run(r_wr, r_ad, r_wd, r_d, r_lo, r_hi, r_junk);
        end

        @(posedge Clock); #1;
        chk("final_idle_cs", {15'd0, ChipSelect}, 16'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
